// File: rtl/mips_boot_pkg.sv
`default_nettype none
// mips_boot_pkg -- state encoding and image-format constants shared by the boot loader.
// Revision 1.0
package mips_boot_pkg;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } boot_state_e;

endpackage
`default_nettype wire

// File: rtl/boot_timeout_cnt.sv
`default_nettype none
// boot_timeout_cnt -- loadable down-counter; expire marks the last enabled cycle before it empties.
// Revision 1.0
module boot_timeout_cnt #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(TIMEOUT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Firing at count 1 means exactly TIMEOUT idle cycles elapse before the error state.
  assign expire = en && (cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// imem_boot_loader -- loads a big-endian byte-stream image into instruction memory, then releases the CPU.
// Revision 1.0
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [31:0]       cpu_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned  HDR_W = HDR_BYTES * 8;
  localparam int unsigned  SR_W  = (WORD_BYTES - 1) * 8;
  localparam logic [HDR_W:0] DEPTH = (HDR_W + 1)'(1) << ADDR_W;

  boot_state_e       state, state_nxt;
  logic [7:0]        hdr_hi;
  logic [SR_W-1:0]   word_sr;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] load_addr;
  logic [HDR_W:0]    remaining;
  logic [HDR_W:0]    hdr_n;
  logic              loading;
  logic              accept;
  logic              tmo_load;
  logic              tmo_expire;
  logic              unused_pc_bits;

  assign loading  = (state == ST_HDR_HI) || (state == ST_HDR_LO) || (state == ST_DATA);
  assign accept   = rx_valid && rx_ready && !boot_start;
  assign hdr_n    = {1'b0, hdr_hi, rx_data};
  assign tmo_load = boot_start || accept;

  boot_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmo_load),
    .en     (loading),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR_HI: begin
        if (accept)          state_nxt = ST_HDR_LO;
        else if (tmo_expire) state_nxt = ST_ERR;
      end
      ST_HDR_LO: begin
        if (accept) begin
          if (hdr_n == '0)         state_nxt = ST_RUN;
          else if (hdr_n > DEPTH)  state_nxt = ST_ERR;
          else                     state_nxt = ST_DATA;
        end else if (tmo_expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (byte_idx == 2'(WORD_BYTES - 1)) state_nxt = ST_WRITE;
        end else if (tmo_expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_WRITE: state_nxt = (remaining == (HDR_W + 1)'(1)) ? ST_RUN : ST_DATA;
      ST_IDLE, ST_RUN, ST_ERR: state_nxt = state;
      default: state_nxt = ST_IDLE;
    endcase
    if (boot_start) state_nxt = ST_HDR_HI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b0;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      hdr_hi     <= '0;
      word_sr    <= '0;
      byte_idx   <= '0;
      load_addr  <= '0;
      remaining  <= '0;
    end else begin
      state     <= state_nxt;
      rx_ready  <= state_nxt inside {ST_HDR_HI, ST_HDR_LO, ST_DATA};
      busy      <= state_nxt inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_WRITE};
      done      <= (state_nxt == ST_RUN);
      cpu_rst_n <= (state_nxt == ST_RUN);
      err       <= (state_nxt == ST_ERR);
      imem_we   <= (state_nxt == ST_WRITE);

      // A restart drops any partial word simply by rewinding the byte index.
      if (boot_start) begin
        byte_idx  <= '0;
        load_addr <= '0;
      end else begin
        case (state)
          ST_HDR_HI: if (accept) hdr_hi <= rx_data;
          ST_HDR_LO: begin
            if (accept) begin
              remaining <= hdr_n;
              load_addr <= '0;
              byte_idx  <= '0;
            end
          end
          ST_DATA: begin
            if (accept) begin
              word_sr  <= {word_sr[SR_W-9:0], rx_data};
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'(WORD_BYTES - 1)) imem_wdata <= {word_sr, rx_data};
            end
          end
          ST_WRITE: begin
            load_addr <= load_addr + ADDR_W'(1);
            remaining <= remaining - (HDR_W + 1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr      = (state == ST_RUN) ? cpu_pc[ADDR_W+1:2] : load_addr;
  assign unused_pc_bits = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// tb_imem_boot_loader -- directed image loads checked against a byte-counting model of the loader.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              boot_start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [31:0]       cpu_pc = 32'h0;
  logic              rx_ready, imem_we, cpu_rst_n, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .boot_start (boot_start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .cpu_pc     (cpu_pc),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: image progress expressed as bytes taken and words written.
  typedef enum int {P_IDLE, P_LOAD, P_RUN, P_ERR} phase_t;
  phase_t      m_phase = P_IDLE;
  int          m_bytes = 0, m_n = 0, m_words = 0, m_idle = 0, m_wr_addr = 0;
  bit          m_wr = 1'b0, m_acc = 1'b0;
  logic [31:0] m_word = 32'h0, m_wr_data = 32'h0;

  function automatic bit m_ready();
    return (m_phase == P_LOAD) && !m_wr;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_IDLE; m_bytes = 0; m_n = 0; m_words = 0; m_idle = 0;
      m_wr = 1'b0; m_acc = 1'b0; m_word = 32'h0;
    end else begin
      m_acc = rx_valid && m_ready() && !boot_start;
      if (boot_start) begin
        m_phase = P_LOAD; m_bytes = 0; m_words = 0; m_idle = 0; m_wr = 1'b0; m_word = 32'h0;
      end else if (m_phase == P_LOAD) begin
        if (m_wr) begin
          m_wr = 1'b0;
          m_words++;
          if (m_words == m_n) m_phase = P_RUN;
        end else if (m_acc) begin
          m_idle = 0;
          m_bytes++;
          if (m_bytes == 1) begin
            m_n = int'(rx_data) * 256;
          end else if (m_bytes == 2) begin
            m_n = m_n + int'(rx_data);
            if (m_n == 0)          m_phase = P_RUN;
            else if (m_n > DEPTH)  m_phase = P_ERR;
          end else begin
            m_word = {m_word[23:0], rx_data};
            if ((m_bytes - 2) % 4 == 0) begin
              m_wr = 1'b1;
              m_wr_addr = m_words % DEPTH;
              m_wr_data = m_word;
            end
          end
        end else begin
          m_idle++;
          if (m_idle == TMO) m_phase = P_ERR;
        end
      end
    end
  end

  // Per-cycle compare plus a log of the writes the DUT actually issues.
  int          we_seen = 0;
  logic [31:0] wr_log_data[$];
  int          wr_log_addr[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("rx_ready",  32'(rx_ready),  32'(m_ready()));
      chk("busy",      32'(busy),      32'(m_phase == P_LOAD));
      chk("done",      32'(done),      32'(m_phase == P_RUN));
      chk("err",       32'(err),       32'(m_phase == P_ERR));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_phase == P_RUN));
      chk("imem_we",   32'(imem_we),   32'(m_wr));
      chk("imem_addr", 32'(imem_addr),
          (m_phase == P_RUN) ? 32'(cpu_pc[ADDR_W+1:2]) : 32'(m_words % DEPTH));
      if (m_wr) chk("imem_wdata", imem_wdata, m_wr_data);
      if (imem_we) begin
        we_seen++;
        wr_log_data.push_back(imem_wdata);
        wr_log_addr.push_back(int'(imem_addr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      tick();
      k++;
    end while (!m_acc && k < 16);
    if (!m_acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte: byte %h not taken after %0d cycles, expected acceptance", b, k);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd);
    send_byte(wd[31:24]); send_byte(wd[23:16]); send_byte(wd[15:8]); send_byte(wd[7:0]);
  endtask

  task automatic pulse_start();
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
  endtask

  task automatic chk_write(input string nm, input int idx, input int addr, input logic [31:0] data);
    if (idx >= 0 && idx < wr_log_data.size()) begin
      chk({nm, "_addr"}, 32'(wr_log_addr[idx]), 32'(addr));
      chk({nm, "_data"}, wr_log_data[idx], data);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: write #%0d missing, only %0d writes seen, expected %h@%0d",
               nm, idx, wr_log_data.size(), data, addr);
    end
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, "_cpu_rst_n"},  32'(cpu_rst_n), 32'd0);
    chk({nm, "_imem_we"},    32'(imem_we),   32'd0);
    chk({nm, "_imem_wdata"}, imem_wdata,     32'd0);
    chk({nm, "_rx_ready"},   32'(rx_ready),  32'd0);
    chk({nm, "_busy"},       32'(busy),      32'd0);
    chk({nm, "_done"},       32'(done),      32'd0);
    chk({nm, "_err"},        32'(err),       32'd0);
    chk({nm, "_imem_addr"},  32'(imem_addr), 32'd0);
  endtask

  int base;

  initial begin
    #2;
    chk_reset_values("por");
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Two-word image from the reference byte list.
    base = we_seen;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h3C01_0010);
    send_word(32'hAC01_0000);
    tick(2);
    chk("t1_we_count", 32'(we_seen - base), 32'd2);
    chk_write("t1_wr0", base, 0, 32'h3C01_0010);
    chk_write("t1_wr1", base + 1, 1, 32'hAC01_0000);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    cpu_pc = 32'h0000_0004;
    tick();
    chk("t1_fetch_addr", 32'(imem_addr), 32'd1);

    // Empty image goes straight to run.
    base = we_seen;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    tick(2);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_we_count", 32'(we_seen - base), 32'd0);

    // Oversized header (1025 words) is rejected; restart clears the error.
    pulse_start();
    send_byte(8'h04); send_byte(8'h01);
    tick();
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("t3_rx_ready", 32'(rx_ready), 32'd0);
    pulse_start();
    chk("t3_err_cleared", 32'(err), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);

    // Stall after three data bytes of a one-word image.
    base = we_seen;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    tick(TMO + 2);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_we_count", 32'(we_seen - base), 32'd0);

    // Restart from run and reload address 0.
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h1234_5678);
    tick(2);
    pulse_start();
    chk("t5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hDEAD_BEEF);
    tick(2);
    chk("t5_done_again", 32'(done), 32'd1);
    chk_write("t5_reload", wr_log_data.size() - 1, 0, 32'hDEAD_BEEF);

    // Restart colliding with a valid byte mid-word: byte dropped, partial word discarded.
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB);
    boot_start = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'hFF;
    tick();
    boot_start = 1'b0;
    rx_valid   = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h1122_3344);
    tick(2);
    chk_write("t6_collide", wr_log_data.size() - 1, 0, 32'h1122_3344);
    chk("t6_done", 32'(done), 32'd1);

    // Full-depth image: last write lands at the top address.
    base = we_seen;
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < DEPTH; i++) send_word(32'hA500_0000 | 32'(i));
    tick(2);
    chk("t7_we_count", 32'(we_seen - base), 32'(DEPTH));
    chk_write("t7_first", base, 0, 32'hA500_0000);
    chk_write("t7_last", base + DEPTH - 1, DEPTH - 1, 32'hA500_03FF);
    chk("t7_done", 32'(done), 32'd1);
    cpu_pc = 32'hFFFF_F008;
    tick();
    chk("t7_fetch_addr", 32'(imem_addr), 32'd2);

    // Asynchronous reset two bytes into a word.
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'h66);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("arst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("t8_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_rx_ready", 32'(rx_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot controller for the single-cycle MIPS core.
- Receives a byte-stream program image and writes it word-by-word into instruction memory, holding the CPU in reset meanwhile.
- Releases the CPU once the image is complete.
- Owns the instruction-memory address/write port and muxes it between the loader and the CPU fetch path.

Parameters:
ADDR_W, 10, instruction-memory word-address width (depth 2^ADDR_W = 1024 words)
TIMEOUT, 1000, max clk cycles between accepted bytes while loading before error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
boot_start  input  1  single-cycle pulse; starts (or restarts) a load
rx_valid  input  1  byte-stream valid
rx_data  input  8  byte-stream data
rx_ready  output  1  loader accepts byte this cycle when rx_valid&&rx_ready
cpu_pc  input  32  CPU fetch address (byte address)
imem_addr  output  ADDR_W  instruction-memory word address
imem_wdata  output  32  instruction-memory write data
imem_we  output  1  instruction-memory write enable
cpu_rst_n  output  1  active-low reset to CPU core
busy  output  1  load in progress
done  output  1  image loaded, CPU running
err  output  1  load aborted

Behaviour:
- Reset (async, rst_n=0): state IDLE; cpu_rst_n=0, imem_we=0, imem_wdata=0, rx_ready=0, busy=0, done=0, err=0; word address, byte index, remaining count and timeout counter cleared.
- Image format: 2-byte header N (word count, big-endian), then N words of 4 bytes each, big-endian (first byte -> bits 31:24).
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, RUN, ERR. All outputs are registered.
- IDLE: CPU held in reset. boot_start -> HDR_HI.
- HDR_HI: rx_ready=1; accepted byte -> N[15:8]; go to HDR_LO.
- HDR_LO: rx_ready=1; accepted byte -> N[7:0]; evaluate the full 16-bit N:
  - N=0 -> RUN.
  - N>2^ADDR_W -> ERR.
  - otherwise -> DATA; address=0, remaining=N.
- DATA: rx_ready=1; shift in bytes; the 4th accepted byte -> WRITE.
- WRITE: rx_ready=0; imem_we=1 for exactly one cycle; imem_wdata = assembled word; imem_addr = load address. Then address+1 and remaining-1; remaining reaches 0 -> RUN, else -> DATA.
- RUN: cpu_rst_n=1, done=1, busy=0. imem_addr = cpu_pc[ADDR_W+1:2]; imem_we=0.
- In IDLE, HDR_*, DATA, WRITE and ERR: imem_addr = load address; busy=1 in HDR_*, DATA, WRITE.
- Latency: cpu_rst_n rises on the first cycle in RUN, i.e. one cycle after the final WRITE.
- Timeout: the counter resets on each accepted byte and on entry to HDR_HI. In HDR_HI, HDR_LO or DATA, counter reaching TIMEOUT -> ERR.
- ERR: err=1, cpu_rst_n=0, rx_ready=0; exits only on boot_start.
- boot_start in any state (RUN, ERR, mid-load):
  - -> HDR_HI next cycle.
  - cpu_rst_n=0, done=0, err=0.
  - Byte index, address and timeout cleared.
  - A partially assembled word is discarded.
- boot_start in the same cycle as an accepted byte: boot_start wins and the byte is dropped.
- Address arithmetic is ADDR_W bits. With N=2^ADDR_W the final WRITE is at address 2^ADDR_W-1 and the address wraps to 0 without effect. Remaining count is 16+1 bits wide.
- Async reset mid-load: immediate return to reset values; memory contents are left partially written.

Decomposition:
- Shared package mips_boot_pkg holds:
  - State enum encoding (7 states, 3 bits).
  - HDR_BYTES=2 and WORD_BYTES=4 constants.
- One natural sub-module: boot_timeout_cnt (loadable down-counter with expire flag).
- The imem port mux stays inline.

Test Plan:
- Load N=2, bytes 00 02 3C 01 00 10 AC 01 00 00 -> imem writes 0x3C010010@0 then 0xAC010000@1; imem_we high exactly 2 cycles; cpu_rst_n=1 and done=1 one cycle after the 2nd write; in RUN, cpu_pc=0x4 -> imem_addr=1.
- Header 00 00 -> RUN directly, no imem_we pulses, done=1.
- Header 04 01 (N=1025) -> ERR, err=1, cpu_rst_n=0, rx_ready=0; boot_start -> HDR_HI, err=0.
- N=1, three data bytes then rx_valid low for TIMEOUT cycles -> ERR, no write issued.
- In RUN, pulse boot_start -> cpu_rst_n=0 next cycle, done=0; a new 1-word image reloads address 0 and returns to RUN.
- rst_n low during DATA (2 bytes in) -> all outputs at reset values immediately; after release, state IDLE with cpu_rst_n=0.
